mor1kx_wb32_ibus_dbus_arbiter: RTL

//  Two-master to one-slave Wishbone B3 arbiter. Sits downstream of the MAROCCHINO

---
 rtl/mor1kx_wb32_ibus_dbus_arbiter_if.sv | 26 ++
 rtl/mor1kx_wb32_ibus_dbus_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mor1kx_wb32_ibus_dbus_arbiter_if.sv
// Wishbone B3 32-bit point-to-point bundle shared by the ibus, dbus and merged slave-side ports.
// "master" is the side that issues cycles; "slave" is the side that answers them.
interface mor1kx_wb32_ibus_dbus_arbiter_if;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        stb;
   logic        cyc;
   logic        we;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      output adr, dat_w, stb, cyc, we, sel, cti, bte,
      input  ack, err, rty, dat_r
   );

   modport slave (
      input  adr, dat_w, stb, cyc, we, sel, cti, bte,
      output ack, err, rty, dat_r
   );
endinterface

// File: rtl/mor1kx_wb32_ibus_dbus_arbiter.sv
// Round-robin arbiter merging the ibus and dbus Wishbone masters onto one slave port,
// with burst-atomic ownership, response steering and a stalled-cycle watchdog.
module mor1kx_wb32_ibus_dbus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TOUT_WIDTH     = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   mor1kx_wb32_ibus_dbus_arbiter_if.slave     iwb,
   mor1kx_wb32_ibus_dbus_arbiter_if.slave     dwb,
   mor1kx_wb32_ibus_dbus_arbiter_if.master    wbm
);

   localparam logic [TOUT_WIDTH-1:0] WDOG_MAX  = '1;
   localparam logic [TOUT_WIDTH-1:0] WDOG_LAST = TOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TOUT} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;       // 0 = ibus, 1 = dbus
   logic                  last_q, last_d;
   logic                  tout_first_q, tout_first_d;
   logic [TOUT_WIDTH-1:0] wdog_q, wdog_d;

   logic granted;
   logic own_cyc;
   logic own_stb;
   logic slave_rsp;
   logic winner;
   logic arbitrate;

   assign granted = (state_q == GNT_I) || (state_q == GNT_D);

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_q       <= 1'b0;
         tout_first_q <= 1'b0;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         tout_first_q <= tout_first_d;
         wdog_q       <= wdog_d;
      end
   end

   // Next state: arbitration on release/idle, watchdog counting while the owner is stalled
   always_comb begin : next_state
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      tout_first_d = 1'b0;
      wdog_d       = '0;
      arbitrate    = 1'b0;
      own_cyc      = owner_q ? dwb.cyc : iwb.cyc;
      own_stb      = owner_q ? dwb.stb : iwb.stb;
      slave_rsp    = wbm.ack | wbm.err | wbm.rty;
      // with both requesting, the master that did not win last time goes next
      winner       = (iwb.cyc && dwb.cyc) ? ~last_q : dwb.cyc;

      unique case (state_q)
         IDLE: arbitrate = 1'b1;
         GNT_I, GNT_D: begin
            if (!own_cyc) begin
               arbitrate = 1'b1;
            end else if (slave_rsp) begin
               wdog_d = '0;
            end else if (own_stb) begin
               if ((TIMEOUT_CYCLES != 0) && (wdog_q == WDOG_LAST)) begin
                  state_d      = TOUT;
                  tout_first_d = 1'b1;
               end else begin
                  wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + TOUT_WIDTH'(1);
               end
            end else begin
               wdog_d = wdog_q;
            end
         end
         TOUT: begin
            if (!own_cyc) arbitrate = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (arbitrate) begin
         if (iwb.cyc || dwb.cyc) begin
            state_d = winner ? GNT_D : GNT_I;
            owner_d = winner;
            last_d  = winner;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // Request mirroring to the slave and response steering back to the owner only
   always_comb begin : out_mux
      wbm.adr   = '0;
      wbm.dat_w = '0;
      wbm.stb   = 1'b0;
      wbm.cyc   = 1'b0;
      wbm.we    = 1'b0;
      wbm.sel   = '0;
      wbm.cti   = '0;
      wbm.bte   = '0;
      iwb.ack   = 1'b0;
      iwb.err   = 1'b0;
      iwb.rty   = 1'b0;
      iwb.dat_r = '0;
      dwb.ack   = 1'b0;
      dwb.err   = 1'b0;
      dwb.rty   = 1'b0;
      dwb.dat_r = '0;

      if (granted && owner_q) begin
         wbm.adr   = dwb.adr;
         wbm.dat_w = dwb.dat_w;
         wbm.stb   = dwb.stb;
         wbm.cyc   = dwb.cyc;
         wbm.we    = dwb.we;
         wbm.sel   = dwb.sel;
         wbm.cti   = dwb.cti;
         wbm.bte   = dwb.bte;
         dwb.ack   = wbm.ack;
         dwb.err   = wbm.err;
         dwb.rty   = wbm.rty;
         dwb.dat_r = wbm.dat_r;
      end else if (granted) begin
         wbm.adr   = iwb.adr;
         wbm.dat_w = iwb.dat_w;
         wbm.stb   = iwb.stb;
         wbm.cyc   = iwb.cyc;
         wbm.we    = iwb.we;
         wbm.sel   = iwb.sel;
         wbm.cti   = iwb.cti;
         wbm.bte   = iwb.bte;
         iwb.ack   = wbm.ack;
         iwb.err   = wbm.err;
         iwb.rty   = wbm.rty;
         iwb.dat_r = wbm.dat_r;
      end else if (state_q == TOUT) begin
         iwb.err = tout_first_q & ~owner_q;
         dwb.err = tout_first_q & owner_q;
      end
   end

endmodule
